// File: rtl/load_store_unit.sv
// Load/store unit: byte, halfword and word accesses over a 32-bit valid/ready
// data-memory bus. A misaligned access is split into two word beats. Load data
// is returned sign- or zero-extended, and the core is stalled while busy.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        store_size,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [31:0]       rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t state, state_next;

  logic              accept;
  logic              is_load_in;
  logic              illegal_in;
  logic              split_in;
  logic [1:0]        size_code;
  logic [2:0]        nbytes_in;
  logic [1:0]        off_in;
  logic [7:0]        mask_in;
  logic [63:0]       data_in;
  logic [ADDR_W-1:0] word_addr_in;

  logic              cap_load;
  logic              cap_split;
  logic [1:0]        cap_off;
  logic [2:0]        cap_funct3;
  logic [ADDR_W-1:0] hi_addr;
  logic [3:0]        hi_wstrb;
  logic [31:0]       hi_wdata;
  logic [31:0]       buf_lo;

  logic [63:0]       load_buf;
  logic [31:0]       load_shift;
  logic [31:0]       load_ext;

  assign req_ready = (state == IDLE) && RST_N;
  assign busy      = (state != IDLE);
  assign accept    = (state == IDLE) && req_valid && req_ready;

  // Decode the live request: access size, split decision, lane mask and lane-aligned data
  always_comb begin
    is_load_in   = (store_size == 2'b11);
    illegal_in   = is_load_in && ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111));
    size_code    = is_load_in ? funct3[1:0] : store_size;
    case (size_code)
      2'b00:   nbytes_in = 3'd1;
      2'b01:   nbytes_in = 3'd2;
      default: nbytes_in = 3'd4;
    endcase
    off_in       = addr[1:0];
    split_in     = ({1'b0, off_in} + nbytes_in) > 3'd4;
    mask_in      = ((8'd1 << nbytes_in) - 8'd1) << off_in;
    data_in      = {32'd0, wdata} << {off_in, 3'b000};
    word_addr_in = {addr[ADDR_W-1:2], 2'b00};
  end

  // Assemble the load result from the beat buffer, then extend it per the load type
  always_comb begin
    load_buf   = (state == BEAT1) ? {mem_rdata, buf_lo} : {32'd0, mem_rdata};
    load_shift = load_buf[{cap_off, 3'b000} +: 32];
    case (cap_funct3)
      3'b000:  load_ext = {{24{load_shift[7]}}, load_shift[7:0]};
      3'b001:  load_ext = {{16{load_shift[15]}}, load_shift[15:0]};
      3'b100:  load_ext = {24'd0, load_shift[7:0]};
      3'b101:  load_ext = {16'd0, load_shift[15:0]};
      default: load_ext = load_shift;
    endcase
  end

  // Next-state logic: illegal loads skip the bus, split accesses take a second beat
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = illegal_in ? RESP : BEAT0;
      BEAT0:   if (mem_ready) state_next = cap_split ? BEAT1 : RESP;
      BEAT1:   if (mem_ready) state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_next;
  end

  // Bus outputs, captured request and response registers, held stable until each beat is accepted
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_wstrb  <= 4'b0000;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      done       <= 1'b0;
      fault      <= 1'b0;
      rdata      <= 32'd0;
      cap_load   <= 1'b0;
      cap_split  <= 1'b0;
      cap_off    <= 2'b00;
      cap_funct3 <= 3'b000;
      hi_addr    <= '0;
      hi_wstrb   <= 4'b0000;
      hi_wdata   <= 32'd0;
      buf_lo     <= 32'd0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cap_load   <= is_load_in;
            cap_split  <= split_in;
            cap_off    <= off_in;
            cap_funct3 <= funct3;
            if (illegal_in) begin
              done  <= 1'b1;
              fault <= 1'b1;
              rdata <= 32'd0;
            end else begin
              mem_valid <= 1'b1;
              mem_addr  <= word_addr_in;
              mem_we    <= !is_load_in;
              mem_wstrb <= is_load_in ? 4'b0000 : mask_in[3:0];
              mem_wdata <= is_load_in ? 32'd0 : data_in[31:0];
              hi_addr   <= word_addr_in + {{(ADDR_W-3){1'b0}}, 3'b100};
              hi_wstrb  <= is_load_in ? 4'b0000 : mask_in[7:4];
              hi_wdata  <= is_load_in ? 32'd0 : data_in[63:32];
            end
          end
        end
        BEAT0: begin
          if (mem_ready) begin
            buf_lo <= mem_rdata;
            if (cap_split) begin
              mem_addr  <= hi_addr;
              mem_wstrb <= hi_wstrb;
              mem_wdata <= hi_wdata;
            end else begin
              mem_valid <= 1'b0;
              mem_we    <= 1'b0;
              mem_wstrb <= 4'b0000;
              done      <= 1'b1;
              if (cap_load) rdata <= load_ext;
            end
          end
        end
        BEAT1: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            done      <= 1'b1;
            if (cap_load) rdata <= load_ext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed vector table, hand-written stall and
// reset sequences, and randomized traffic against a byte-level memory model.
module tb_load_store_unit;

  localparam int ADDR_W = 32;

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic        we;
  } beat_t;

  typedef struct {
    logic [1:0]  sz;
    logic [2:0]  f3;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [31:0] rd0;
    logic [31:0] rd1;
    int          nb;
    logic [31:0] a0;
    logic [3:0]  s0;
    logic [31:0] d0;
    logic [31:0] a1;
    logic [3:0]  s1;
    logic [31:0] d1;
    logic        we;
    logic [31:0] exp_rd;
    logic        exp_fault;
    int          lat;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  store_size;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] rdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] bus_mem [32];
  logic [7:0]  ref_mem [128];
  beat_t       seen [$];
  vec_t        vecs [$];

  int compared   = 0;
  int mismatched = 0;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_ready(req_ready),
    .store_size(store_size), .funct3(funct3), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .fault(fault), .rdata(rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Free-running clock
  always #5 CLK = ~CLK;

  // Two 64-byte windows (bottom and top of the address space); other addresses alias into them
  function automatic int widx(input logic [31:0] a);
    return (a[31] ? 16 : 0) + int'(a[5:2]);
  endfunction

  function automatic int bidx(input logic [31:0] a);
    return (a[31] ? 64 : 0) + int'(a[5:0]);
  endfunction

  assign mem_rdata = bus_mem[widx(mem_addr)];

  function automatic vec_t mk(input logic [1:0] sz, input logic [2:0] f3, input logic [31:0] ad,
                              input logic [31:0] wd, input logic [31:0] rd0, input logic [31:0] rd1,
                              input int nb, input logic [31:0] a0, input logic [3:0] s0,
                              input logic [31:0] d0, input logic [31:0] a1, input logic [3:0] s1,
                              input logic [31:0] d1, input logic we, input logic [31:0] exp_rd,
                              input logic exp_fault, input int lat);
    vec_t v;
    v.sz = sz; v.f3 = f3; v.ad = ad; v.wd = wd; v.rd0 = rd0; v.rd1 = rd1; v.nb = nb;
    v.a0 = a0; v.s0 = s0; v.d0 = d0; v.a1 = a1; v.s1 = s1; v.d1 = d1; v.we = we;
    v.exp_rd = exp_rd; v.exp_fault = exp_fault; v.lat = lat;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one cycle, acting as the memory: accepted write beats update bus_mem
  task automatic tick();
    if (mem_valid && mem_ready && mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_wstrb[i]) bus_mem[widx(mem_addr)][8*i +: 8] = mem_wdata[8*i +: 8];
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] sz, input logic [2:0] f3,
                               input logic [31:0] ad, input logic [31:0] wd);
    store_size = sz;
    funct3     = f3;
    addr       = ad;
    wdata      = wd;
    req_valid  = 1'b1;
  endtask

  // Issue one request and follow it to done, recording bus beats and checking stalls hold the bus
  task automatic runOp(input logic [1:0] sz, input logic [2:0] f3, input logic [31:0] ad,
                       input logic [31:0] wd, input bit rnd_ready, output int lat,
                       output int stalls, output bit got_done, output logic [31:0] rd,
                       output logic flt);
    logic [31:0] pa;
    logic [31:0] pd;
    logic [5:0]  pc;
    bit          held;
    seen.delete();
    lat = 0; stalls = 0; got_done = 1'b0; rd = 32'd0; flt = 1'b0; held = 1'b0;
    pa = 32'd0; pd = 32'd0; pc = 6'd0;
    applyStimulus(sz, f3, ad, wd);
    mem_ready = 1'b1;
    checkOutput("accept_ready", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid  = 1'b0;
    addr       = $urandom;
    wdata      = $urandom;
    store_size = 2'($urandom_range(0, 3));
    funct3     = 3'($urandom_range(0, 7));
    lat = 1;
    while (!done && lat < 64) begin
      checkOutput("busy_stall", {30'd0, busy, req_ready}, 32'd2);
      if (held) begin
        checkOutput("hold_addr", mem_addr, pa);
        checkOutput("hold_data", mem_wdata, pd);
        checkOutput("hold_ctl", {26'd0, mem_valid, mem_we, mem_wstrb}, {26'd0, pc});
      end
      mem_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (mem_valid && mem_ready)
        seen.push_back('{a: mem_addr, s: mem_wstrb, d: mem_wdata, we: mem_we});
      else if (mem_valid)
        stalls++;
      held = mem_valid && !mem_ready;
      pa = mem_addr; pd = mem_wdata; pc = {mem_valid, mem_we, mem_wstrb};
      tick();
      lat++;
    end
    if (done) begin
      got_done = 1'b1;
      rd  = rdata;
      flt = fault;
      checkOutput("resp_busy", {30'd0, busy, req_ready}, 32'd2);
    end
    mem_ready = 1'b1;
    tick();
  endtask

  initial begin
    int          lat, stalls;
    bit          got_done;
    logic [31:0] rd;
    logic        flt;
    logic [31:0] mdl_rd;

    RST_N = 1'b0; req_valid = 1'b0; store_size = 2'b00; funct3 = 3'b000;
    addr = 32'd0; wdata = 32'd0; mem_ready = 1'b1;
    for (int w = 0; w < 32; w++) bus_mem[w] = 32'd0;

    // Reset state
    tick(); tick();
    checkOutput("rst_ready_low", {31'd0, req_ready}, 32'd0);
    checkOutput("rst_ctl", {28'd0, mem_valid, mem_we, done, fault}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    checkOutput("rst_addr", mem_addr, 32'd0);
    checkOutput("rst_wdata", mem_wdata, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    RST_N = 1'b1;
    tick();
    checkOutput("rst_ready_high", {31'd0, req_ready}, 32'd1);

    // Directed vectors: sz f3 addr wdata rd0 rd1 | beats a0 s0 d0 a1 s1 d1 we rdata fault latency
    vecs.push_back(mk(2'b10, 3'b000, 32'h100, 32'hDEADBEEF, 0, 0, 1, 32'h100, 4'b1111, 32'hDEADBEEF, 0, 0, 0, 1, 32'h0, 0, 2));
    vecs.push_back(mk(2'b00, 3'b000, 32'h103, 32'h000000A5, 0, 0, 1, 32'h100, 4'b1000, 32'hA5000000, 0, 0, 0, 1, 32'h0, 0, 2));
    vecs.push_back(mk(2'b10, 3'b000, 32'h0FF, 32'h44332211, 0, 0, 2, 32'h0FC, 4'b1000, 32'h11000000, 32'h100, 4'b0111, 32'h00443322, 1, 32'h0, 0, 3));
    vecs.push_back(mk(2'b11, 3'b001, 32'h202, 0, 32'h80011234, 0, 1, 32'h200, 4'b0000, 0, 0, 0, 0, 0, 32'hFFFF8001, 0, 2));
    vecs.push_back(mk(2'b11, 3'b101, 32'h202, 0, 32'h80011234, 0, 1, 32'h200, 4'b0000, 0, 0, 0, 0, 0, 32'h00008001, 0, 2));
    vecs.push_back(mk(2'b11, 3'b000, 32'h200, 0, 32'h80011234, 0, 1, 32'h200, 4'b0000, 0, 0, 0, 0, 0, 32'h00000034, 0, 2));
    vecs.push_back(mk(2'b01, 3'b000, 32'h102, 32'h00001234, 0, 0, 1, 32'h100, 4'b1100, 32'h12340000, 0, 0, 0, 1, 32'h00000034, 0, 2));
    vecs.push_back(mk(2'b01, 3'b000, 32'h0FF, 32'h0000ABCD, 0, 0, 2, 32'h0FC, 4'b1000, 32'hCD000000, 32'h100, 4'b0001, 32'h000000AB, 1, 32'h00000034, 0, 3));
    vecs.push_back(mk(2'b11, 3'b010, 32'h0FE, 0, 32'hBBAA0000, 32'h0000DDCC, 2, 32'h0FC, 4'b0000, 0, 32'h100, 4'b0000, 0, 0, 32'hDDCCBBAA, 0, 3));
    vecs.push_back(mk(2'b11, 3'b010, 32'hFFFFFFFE, 0, 32'h22110000, 32'h00004433, 2, 32'hFFFFFFFC, 4'b0000, 0, 32'h0, 4'b0000, 0, 0, 32'h44332211, 0, 3));
    vecs.push_back(mk(2'b11, 3'b000, 32'h100, 0, 32'h12345680, 0, 1, 32'h100, 4'b0000, 0, 0, 0, 0, 0, 32'hFFFFFF80, 0, 2));
    vecs.push_back(mk(2'b11, 3'b101, 32'h103, 0, 32'hAA000000, 32'h000000BB, 2, 32'h100, 4'b0000, 0, 32'h104, 4'b0000, 0, 0, 32'h0000BBAA, 0, 3));
    vecs.push_back(mk(2'b11, 3'b011, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1));
    vecs.push_back(mk(2'b00, 3'b000, 32'h001, 32'h00000077, 0, 0, 1, 32'h000, 4'b0010, 32'h00007700, 0, 0, 0, 1, 32'h0, 0, 2));
    vecs.push_back(mk(2'b11, 3'b110, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1));
    vecs.push_back(mk(2'b11, 3'b010, 32'h104, 0, 32'hCAFEF00D, 0, 1, 32'h104, 4'b0000, 0, 0, 0, 0, 0, 32'hCAFEF00D, 0, 2));
    vecs.push_back(mk(2'b11, 3'b111, 32'h104, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1));

    foreach (vecs[i]) begin
      if (!vecs[i].we && vecs[i].nb > 0) begin
        bus_mem[widx(vecs[i].a0)] = vecs[i].rd0;
        if (vecs[i].nb > 1) bus_mem[widx(vecs[i].a1)] = vecs[i].rd1;
      end
      runOp(vecs[i].sz, vecs[i].f3, vecs[i].ad, vecs[i].wd, 1'b0, lat, stalls, got_done, rd, flt);
      checkOutput($sformatf("v%0d_done", i), {31'd0, got_done}, 32'd1);
      checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      checkOutput($sformatf("v%0d_beats", i), seen.size(), vecs[i].nb);
      if (seen.size() > 0) begin
        checkOutput($sformatf("v%0d_b0_addr", i), seen[0].a, vecs[i].a0);
        checkOutput($sformatf("v%0d_b0_ctl", i), {27'd0, seen[0].we, seen[0].s}, {27'd0, vecs[i].we, vecs[i].s0});
        if (vecs[i].we) checkOutput($sformatf("v%0d_b0_data", i), seen[0].d, vecs[i].d0);
      end
      if (seen.size() > 1) begin
        checkOutput($sformatf("v%0d_b1_addr", i), seen[1].a, vecs[i].a1);
        checkOutput($sformatf("v%0d_b1_ctl", i), {27'd0, seen[1].we, seen[1].s}, {27'd0, vecs[i].we, vecs[i].s1});
        if (vecs[i].we) checkOutput($sformatf("v%0d_b1_data", i), seen[1].d, vecs[i].d1);
      end
      checkOutput($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      checkOutput($sformatf("v%0d_fault", i), {31'd0, flt}, {31'd0, vecs[i].exp_fault});
    end

    // Bus stall during a word load, with a stray request that must be ignored
    bus_mem[widx(32'h40)] = 32'h0BADF00D;
    applyStimulus(2'b11, 3'b010, 32'h40, 32'd0);
    mem_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checkOutput("stall_addr", mem_addr, 32'h40);
      checkOutput("stall_ctl", {27'd0, mem_valid, mem_we, req_ready, busy, done}, {27'd0, 5'b10010});
      if (c == 2) applyStimulus(2'b10, 3'b000, 32'h300, 32'h11111111);
      else req_valid = 1'b0;
      tick();
    end
    req_valid = 1'b0;
    mem_ready = 1'b1;
    tick();
    checkOutput("stall_done", {31'd0, done}, 32'd1);
    checkOutput("stall_rdata", rdata, 32'h0BADF00D);
    tick();
    checkOutput("stall_idle", {30'd0, req_ready, mem_valid}, 32'd2);

    // Reset asserted during the second beat of a split load abandons it
    applyStimulus(2'b11, 3'b010, 32'h0FE, 32'd0);
    tick();
    req_valid = 1'b0;
    tick();
    checkOutput("rstmid_beat1_addr", mem_addr, 32'h100);
    RST_N = 1'b0;
    tick();
    checkOutput("rstmid_ctl", {29'd0, mem_valid, done, req_ready}, 32'd0);
    checkOutput("rstmid_rdata", rdata, 32'd0);
    RST_N = 1'b1;
    tick();
    checkOutput("rstmid_ready", {30'd0, req_ready, done}, 32'd2);

    // Randomized traffic checked against a byte-addressed memory model
    for (int w = 0; w < 32; w++) bus_mem[w] = $urandom;
    for (int b = 0; b < 128; b++) ref_mem[b] = bus_mem[b / 4][8*(b % 4) +: 8];
    mdl_rd = 32'd0;
    for (int t = 0; t < 200; t++) begin
      logic [1:0]  sz;
      logic [2:0]  f3;
      logic [31:0] ad, wd, val, exp_rd;
      bit          is_store, legal;
      int          n, off, exp_beats;
      logic [2:0]  legal_f3 [5];
      legal_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      if ($urandom_range(0, 9) < 4) begin
        sz = 2'($urandom_range(0, 2));
        f3 = 3'($urandom_range(0, 7));
      end else begin
        sz = 2'b11;
        if ($urandom_range(0, 9) == 0) f3 = ($urandom_range(0, 2) == 0) ? 3'b011 : 3'($urandom_range(6, 7));
        else f3 = legal_f3[$urandom_range(0, 4)];
      end
      ad = ($urandom_range(0, 1) ? 32'hFFFFFFC0 : 32'h0) | 32'($urandom_range(0, 63));
      wd = $urandom;
      is_store = (sz != 2'b11);
      legal    = is_store || !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
      if (is_store) n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      else          n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      off       = int'(ad[1:0]);
      exp_beats = !legal ? 0 : (off + n > 4) ? 2 : 1;

      runOp(sz, f3, ad, wd, 1'b1, lat, stalls, got_done, rd, flt);
      checkOutput("rnd_done", {31'd0, got_done}, 32'd1);
      checkOutput("rnd_beats", seen.size(), exp_beats);
      checkOutput("rnd_latency", lat, legal ? exp_beats + 1 + stalls : 1);
      checkOutput("rnd_fault", {31'd0, flt}, {31'd0, !legal});
      for (int k = 0; k < seen.size(); k++) begin
        logic [3:0]  es;
        logic [31:0] ed, lane;
        es = 4'b0000; ed = 32'd0; lane = 32'd0;
        for (int j = 0; j < 4; j++) begin
          int o;
          o = 4*k + j - off;
          if (is_store && o >= 0 && o < n) begin
            es[j] = 1'b1;
            ed[8*j +: 8] = wd[8*o +: 8];
            lane[8*j +: 8] = 8'hFF;
          end
        end
        checkOutput("rnd_beat_addr", seen[k].a, (ad & 32'hFFFFFFFC) + 32'(4*k));
        checkOutput("rnd_beat_ctl", {27'd0, seen[k].we, seen[k].s}, {27'd0, is_store, es});
        checkOutput("rnd_beat_data", seen[k].d & lane, ed);
      end
      if (!legal) begin
        mdl_rd = 32'd0;
      end else if (is_store) begin
        for (int i = 0; i < n; i++) ref_mem[bidx(ad + 32'(i))] = wd[8*i +: 8];
      end else begin
        val = 32'd0;
        for (int i = 0; i < n; i++) val[8*i +: 8] = ref_mem[bidx(ad + 32'(i))];
        case (f3)
          3'b000:  exp_rd = {{24{val[7]}}, val[7:0]};
          3'b001:  exp_rd = {{16{val[15]}}, val[15:0]};
          default: exp_rd = val;
        endcase
        mdl_rd = exp_rd;
      end
      checkOutput("rnd_rdata", rd, mdl_rd);
    end

    // Memory contents written by the unit must match the model
    for (int w = 0; w < 32; w++)
      checkOutput($sformatf("mem_word%0d", w), bus_mem[w],
                  {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the instruction controller.
- Consumes the controller's memory_en, store_size and funct3 together with the ALU-computed address and rs2 data.
- Performs byte/halfword/word loads and stores over a 32-bit valid/ready data-memory bus, splitting misaligned accesses into two word beats.
- Returns sign- or zero-extended load data for the register write-back mux (wdSelect = 01) and stalls the core while busy.

Parameters:
ADDR_W, 32, address width. The design is fixed at 32; the parameter exists for lint/bench only.

Ports:
CLK  in  1  clock, all state on rising edge
RST_N  in  1  synchronous active-low reset
req_valid  in  1  memory op requested (controller memory_en qualified by stage valid)
req_ready  out  1  unit idle and able to accept
store_size  in  2  00 byte / 01 half / 10 word store; 11 = load
funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
addr  in  32  byte address from ALU
wdata  in  32  store data (rs2), right-aligned
busy  out  1  stall request, high whenever state != IDLE
done  out  1  one-cycle completion pulse
fault  out  1  valid with done; illegal load funct3
rdata  out  32  load result, valid with done, held until next done
mem_valid  out  1  bus request
mem_ready  in  1  bus accept (write accepted / read data valid)
mem_addr  out  32  word-aligned bus address
mem_we  out  1  1 = write
mem_wstrb  out  4  byte-lane write enables
mem_wdata  out  32  lane-aligned write data
mem_rdata  in  32  read data, sampled when mem_valid && mem_ready

Behaviour:
- Reset (RST_N low at edge):
  - State goes to IDLE.
  - Registered outputs clear: mem_valid, mem_we, done, fault = 0; mem_wstrb = 0000; mem_addr, mem_wdata, rdata = 0.
  - req_ready = (state == IDLE) && RST_N, so it is low while reset is asserted.
  - Reset mid-transaction abandons the transaction; mem_valid is 0 from the next cycle.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- Accept:
  - Accept occurs in IDLE when req_valid && req_ready.
  - addr, wdata, store_size and funct3 are captured on accept; later input changes have no effect.
  - req_valid outside IDLE is ignored.
- Size encoding:
  - Access size n: stores use store_size (1/2/4 bytes).
  - Loads use funct3: 000/100 → 1 byte, 001/101 → 2 bytes, 010 → 4 bytes.
  - Loads with funct3 011, 110 or 111 are illegal.
- Split rule: off = addr[1:0]. The access is split when off + n > 4.
- Transitions:
  - IDLE → RESP on accepting an illegal load (no bus activity).
  - IDLE → BEAT0 on accepting any other request.
  - BEAT0 → BEAT1 on handshake if split; BEAT0 → RESP on handshake otherwise.
  - BEAT1 → RESP on handshake.
  - RESP → IDLE unconditionally.
- Bus rules:
  - In BEAT0/BEAT1, mem_valid = 1.
  - mem_addr, mem_we, mem_wstrb and mem_wdata stay stable until mem_ready.
  - BEAT0 address = {addr[31:2], 00}. BEAT1 address = BEAT0 address + 4, modulo 2^32 (0xFFFFFFFC wraps to 0).
- Stores:
  - mask = (2^n − 1) << off, 8 bits wide. BEAT0 strobes = mask[3:0]; BEAT1 strobes = mask[7:4].
  - Data = wdata << 8·off, 64 bits wide. BEAT0 sends bits [31:0]; BEAT1 sends bits [63:32].
  - mem_we = 1 for stores; mem_wstrb = 0000 for loads.
- Loads:
  - mem_rdata from each beat is captured into a 64-bit buffer (BEAT0 → low word, BEAT1 → high word).
  - Result = (buffer >> 8·off), taking the low n bytes.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- RESP:
  - done = 1 for exactly one cycle.
  - fault = 1 only on the illegal-load path; in that case rdata = 0.
  - Stores leave rdata unchanged.
- Latency (accept at cycle T, mem_ready tied high): aligned op → done at T+2; split op → T+3; illegal load → T+1.
- Each mem_ready low cycle adds one cycle of latency.
- busy stays high from T+1 through the RESP cycle inclusive.

Test Plan:
1. SW addr 0x100, wdata 0xDEADBEEF, mem_ready = 1 → one beat: mem_addr 0x100, wstrb 1111, mem_wdata 0xDEADBEEF, mem_we 1; done at T+2, fault 0.
2. SB addr 0x103, wdata 0x000000A5 → wstrb 1000, mem_wdata 0xA5000000. Then SW addr 0x0FF, wdata 0x44332211 → beat0 addr 0x0FC, wstrb 1000, data 0x11000000; beat1 addr 0x100, wstrb 0111, data 0x00443322.
3. LH funct3 001, addr 0x202, mem_rdata 0x80011234 → rdata 0xFFFF8001. Same with LHU (101) → 0x00008001. LB at 0x200 → 0x00000034.
4. LW addr 0x0FE: beat0 mem_rdata 0xBBAA0000, beat1 mem_rdata 0x0000DDCC → rdata 0xDDCCBBAA; done at T+3. LW at 0xFFFFFFFE → beat1 mem_addr 0x00000000.
5. mem_ready low for 5 cycles during LW addr 0x40 → mem_valid, mem_addr, mem_we stable; req_ready 0, busy 1, no done. done arrives 1 cycle after mem_ready rises. A req_valid pulse during the wait is ignored.
6. Load funct3 011 → mem_valid never asserted; done = fault = 1 at T+1, rdata 0. Separately, RST_N low during BEAT1 → mem_valid 0 next cycle, no done; req_ready 1 on the first cycle after RST_N returns high.
